// File: rtl/obstacle_lane_gen.sv
// obstacle_lane_gen: LFSR-driven obstacle spawner with per-lane repeat limiting and valid/ack offer handshake.
// Ports: ck (clock), rst_n (async active-low reset), enable (game running), tick (frame strobe),
//        period (ticks between spawns, 0 acts as 1), spawn_ack (consumer accepts offer),
//        spawn_valid (offer pending), lane (lane index), position (lane*LANE_PITCH),
//        check (active-low lane-blocked mask).
module obstacle_lane_gen #(
  parameter int          NUM_LANES  = 4,
  parameter int          LANE_PITCH = 125,
  parameter int          POS_W      = 9,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          MAX_REPEAT = 2,
  localparam int         LANE_W     = $clog2(NUM_LANES)
) (
  input  logic                 ck,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 tick,
  input  logic [7:0]           period,
  input  logic                 spawn_ack,
  output logic                 spawn_valid,
  output logic [LANE_W-1:0]    lane,
  output logic [POS_W-1:0]     position,
  output logic [NUM_LANES-1:0] check
);
  typedef enum logic [1:0] {IDLE, COUNT, OFFER} state_t;
  localparam logic [LANE_W:0] NL   = (LANE_W+1)'(NUM_LANES);
  localparam logic [15:0]     SEED = (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;
  localparam logic [3:0]      MR   = 4'(MAX_REPEAT);
  state_t                 state_q, state_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [7:0]             cnt_q, cnt_d, load;
  logic [3:0]             rep_q, rep_d;
  logic [LANE_W-1:0]      last_q, last_d, lane_q, lane_d, cand, sel;
  logic                   last_v_q, last_v_d, valid_q, valid_d;
  logic [POS_W-1:0]       pos_q, pos_d;
  logic [NUM_LANES-1:0]   check_q, check_d;
  logic [LANE_W:0]        raw;
  always_comb begin
    raw      = {1'b0, lfsr_q[LANE_W-1:0]};
    // raw < 2*NUM_LANES, so one conditional subtraction folds it into range
    cand     = LANE_W'(raw >= NL ? raw - NL : raw);
    sel      = (last_v_q && cand == last_q && rep_q == MR)
             ? (({1'b0, cand} + (LANE_W+1)'(1) == NL) ? '0 : cand + LANE_W'(1)) : cand;
    load     = (period == 8'd0) ? 8'd1 : period;
    lfsr_d   = enable ? {lfsr_q[14:0], ^(lfsr_q & 16'hB400)} : lfsr_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    rep_d    = rep_q;
    last_d   = last_q;
    last_v_d = last_v_q;
    valid_d  = valid_q;
    lane_d   = lane_q;
    pos_d    = pos_q;
    check_d  = check_q;
    if (!enable) begin
      state_d = IDLE;
      valid_d = 1'b0;
      check_d = '1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = COUNT;
          cnt_d   = load;
        end
        COUNT: if (tick) begin
          if (cnt_q == 8'd1) begin
            state_d = OFFER;
            valid_d = 1'b1;
            lane_d  = sel;
            pos_d   = POS_W'(LANE_PITCH * int'(sel));
            check_d = ~(NUM_LANES'(1) << sel);
          end else cnt_d = cnt_q - 8'd1;
        end
        OFFER: if (spawn_ack) begin
          state_d  = COUNT;
          cnt_d    = load;
          valid_d  = 1'b0;
          rep_d    = (last_v_q && lane_q == last_q) ? ((rep_q == 4'd15) ? rep_q : rep_q + 4'd1) : 4'd1;
          last_d   = lane_q;
          last_v_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED;
      cnt_q    <= '0;
      rep_q    <= '0;
      last_q   <= '0;
      last_v_q <= 1'b0;
      valid_q  <= 1'b0;
      lane_q   <= '0;
      pos_q    <= '0;
      check_q  <= '1;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      rep_q    <= rep_d;
      last_q   <= last_d;
      last_v_q <= last_v_d;
      valid_q  <= valid_d;
      lane_q   <= lane_d;
      pos_q    <= pos_d;
      check_q  <= check_d;
    end
  end
  assign spawn_valid = valid_q;
  assign lane        = lane_q;
  assign position    = pos_q;
  assign check       = check_q;
endmodule

// File: tb/tb_obstacle_lane_gen.sv
// tb_obstacle_lane_gen: vector table, hand sequences and random stimulus against a lane-selection reference model.
module tb_obstacle_lane_gen;
  logic       ck = 1'b0, rst_n, en, tick, ack;
  logic [7:0] per;
  logic       v0, v1;
  logic [1:0] l0, l1;
  logic [8:0] p0;
  logic [9:0] p1;
  logic [3:0] c0;
  logic [2:0] c1;
  int n_cmp = 0, n_err = 0;
  always #5 ck = ~ck;
  obstacle_lane_gen u0 (
    .ck(ck), .rst_n(rst_n), .enable(en), .tick(tick), .period(per), .spawn_ack(ack),
    .spawn_valid(v0), .lane(l0), .position(p0), .check(c0)
  );
  obstacle_lane_gen #(.NUM_LANES(3), .LANE_PITCH(200), .POS_W(10), .MAX_REPEAT(1)) u1 (
    .ck(ck), .rst_n(rst_n), .enable(en), .tick(tick), .period(per), .spawn_ack(ack),
    .spawn_valid(v1), .lane(l1), .position(p1), .check(c1)
  );
  // reference model: instance 0 = defaults, instance 1 = 3 lanes / pitch 200 / max repeat 1
  int NN[2] = '{4, 3};
  int PP[2] = '{125, 200};
  int MX[2] = '{2, 1};
  bit [15:0] ml;
  int mst, mcnt;
  bit mv;
  int mlane[2], mpos[2], mchk[2];
  int hist[2][16];
  int hn[2];
  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    ml  = 16'hACE1;
    mst = 0;
    mcnt = 0;
    mv  = 0;
    for (int i = 0; i < 2; i++) begin
      mlane[i] = 0;
      mpos[i]  = 0;
      mchk[i]  = (1 << NN[i]) - 1;
      hn[i]    = 0;
    end
  endtask
  function automatic int run_len(input int i);
    int r = 0;
    for (int k = hn[i] - 1; k >= 0; k--) begin
      if (hist[i][k] != hist[i][hn[i]-1]) break;
      r++;
    end
    return r > 15 ? 15 : r;
  endfunction
  function automatic int pick(input int i);
    int c = (int'(ml) & 3) % NN[i];
    if (hn[i] > 0 && c == hist[i][hn[i]-1] && run_len(i) == MX[i]) c = (c + 1) % NN[i];
    return c;
  endfunction
  task automatic push_hist(input int i, input int ln);
    if (hn[i] == 16) begin
      for (int k = 0; k < 15; k++) hist[i][k] = hist[i][k+1];
      hn[i] = 15;
    end
    hist[i][hn[i]] = ln;
    hn[i]++;
  endtask
  task automatic model_step();
    int ld = (per == 8'd0) ? 1 : int'(per);
    if (!en) begin
      mst = 0;
      mv  = 0;
      for (int i = 0; i < 2; i++) mchk[i] = (1 << NN[i]) - 1;
    end else if (mst == 0) begin
      mst = 1;
      mcnt = ld;
    end else if (mst == 1) begin
      if (tick) begin
        if (mcnt == 1) begin
          mst = 2;
          mv  = 1;
          for (int i = 0; i < 2; i++) begin
            mlane[i] = pick(i);
            mpos[i]  = mlane[i] * PP[i];
            mchk[i]  = ((1 << NN[i]) - 1) & ~(1 << mlane[i]);
          end
        end else mcnt--;
      end
    end else if (ack) begin
      for (int i = 0; i < 2; i++) push_hist(i, mlane[i]);
      mst = 1;
      mcnt = ld;
      mv  = 0;
    end
    if (en) ml = {ml[14:0], ^(ml & 16'hB400)};
  endtask
  task automatic check_all();
    cmp("valid0", int'(v0), int'(mv));
    cmp("lane0", int'(l0), mlane[0]);
    cmp("pos0", int'(p0), mpos[0]);
    cmp("check0", int'(c0), mchk[0]);
    cmp("valid1", int'(v1), int'(mv));
    cmp("lane1", int'(l1), mlane[1]);
    cmp("pos1", int'(p1), mpos[1]);
    cmp("check1", int'(c1), mchk[1]);
  endtask
  task automatic cyc(input bit e, input bit t, input bit a, input logic [7:0] p);
    en = e; tick = t; ack = a; per = p;
    model_step();
    @(negedge ck);
    check_all();
  endtask
  task automatic check_reset(input string tag);
    cmp({tag, "_valid"}, int'(v0) + int'(v1), 0);
    cmp({tag, "_lane"}, int'(l0) + int'(l1), 0);
    cmp({tag, "_pos"}, int'(p0) + int'(p1), 0);
    cmp({tag, "_check0"}, int'(c0), 15);
    cmp({tag, "_check1"}, int'(c1), 7);
  endtask
  typedef struct {
    bit         e, t, a;
    logic [7:0] p;
    bit         ev;
  } vec_t;
  vec_t tbl[$];
  initial begin
    int guard;
    rst_n = 1'b0; en = 0; tick = 0; ack = 0; per = 0;
    model_reset();
    @(negedge ck);
    @(negedge ck);
    check_reset("reset");
    rst_n = 1'b1;
    // period 3, tick every 4 cycles, ack 2 cycles after valid; then period 0, OFFER hold, enable drop
    tbl.push_back('{1, 0, 0, 3, 0});
    for (int k = 0; k < 2; k++) begin
      tbl.push_back('{1, 1, 0, 3, 0});
      for (int j = 0; j < 3; j++) tbl.push_back('{1, 0, 0, 3, 0});
    end
    tbl.push_back('{1, 1, 0, 3, 1});
    tbl.push_back('{1, 0, 0, 3, 1});
    tbl.push_back('{1, 0, 1, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 1});
    for (int k = 0; k < 10; k++) tbl.push_back('{1, k[0], 0, 0, 1});
    tbl.push_back('{1, 1, 1, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 1});
    tbl.push_back('{0, 1, 0, 2, 0});
    tbl.push_back('{1, 1, 0, 2, 0});
    tbl.push_back('{1, 1, 0, 2, 0});
    tbl.push_back('{1, 1, 0, 2, 1});
    tbl.push_back('{1, 0, 1, 2, 0});
    foreach (tbl[k]) begin
      cyc(tbl[k].e, tbl[k].t, tbl[k].a, tbl[k].p);
      cmp("tbl_valid", int'(v0), int'(tbl[k].ev));
    end
    // asynchronous reset in the middle of COUNT
    for (int k = 0; k < 3; k++) cyc(1, 1, 0, 5);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_reset("async_count");
    @(negedge ck);
    rst_n = 1'b1;
    // asynchronous reset while an offer is pending
    guard = 0;
    while (!v0 && guard < 10) begin
      cyc(1, 1, 0, 1);
      guard++;
    end
    cmp("offer_reached", int'(v0), 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_reset("async_offer");
    @(negedge ck);
    rst_n = 1'b1;
    for (int k = 0; k < 30000; k++)
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 2)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/obstacle_lane_gen.md
OBSTACLE_LANE_GEN -- requirements
Module: obstacle_lane_gen

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, number of lanes (legal 2..16); LANE_W = clog2(NUM_LANES).
REQ-002 SHALL have parameter LANE_PITCH, default 125, pixel spacing between lane origins.
REQ-003 SHALL have parameter POS_W, default 9, position width; (NUM_LANES-1)*LANE_PITCH < 2^POS_W is required.
REQ-004 SHALL have parameter LFSR_SEED, default 16'hACE1, LFSR reset value; a seed of 0 is replaced by 16'h0001.
REQ-005 SHALL have parameter MAX_REPEAT, default 2, max consecutive accepted spawns in the same lane (legal 1..15).
REQ-006 SHALL have port ck  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port enable  input  1  game running; low forces IDLE.
REQ-009 SHALL have port tick  input  1  frame strobe, one ck cycle wide.
REQ-010 SHALL have port period  input  8  ticks between spawns; 0 treated as 1.
REQ-011 SHALL have port spawn_ack  input  1  consumer accepts current offer.
REQ-012 SHALL have port spawn_valid  output  1  offer pending.
REQ-013 SHALL have port lane  output  LANE_W  selected lane index.
REQ-014 SHALL have port position  output  POS_W  lane*LANE_PITCH.
REQ-015 SHALL have port check  output  NUM_LANES  active-low lane-blocked mask; bit lane low, all others high.

Function
REQ-016 SHALL run a 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, stepping every ck cycle while enable=1, holding while enable=0.
REQ-017 SHALL form candidate = lfsr[LANE_W-1:0]; if candidate >= NUM_LANES, subtract NUM_LANES.
REQ-018 SHALL, when candidate equals the last accepted lane and repeat count equals MAX_REPEAT, replace candidate with (candidate+1) mod NUM_LANES.
REQ-019 SHALL compute position as lane*LANE_PITCH in POS_W bits, registered alongside lane and check (all three change on the same edge).
REQ-020 SHALL implement FSM states IDLE, COUNT, OFFER.
REQ-021 IDLE: spawn_valid=0, check all ones; enable=1 -> COUNT with counter loaded from max(period,1).
REQ-022 COUNT: each tick decrements counter; tick with counter=1 -> OFFER, latching lane/position/check on that edge, spawn_valid=1 from the next cycle (latency 1 ck after expiring tick).
REQ-023 OFFER: spawn_valid, lane, position, check held stable; ticks ignored (not accumulated); spawn_ack=1 -> COUNT, counter reloaded from max(period,1), spawn_valid=0 next cycle.
REQ-024 spawn_ack while spawn_valid=0 SHALL be ignored.
REQ-025 On acceptance: repeat count increments (saturating at 15) if lane equals last accepted lane, else set to 1; last accepted lane updated.
REQ-026 check SHALL hold the last offered pattern in COUNT until the next offer.
REQ-027 enable=0 in any state SHALL force IDLE next edge: spawn_valid=0, check all ones, lane/position hold, repeat history kept, pending offer discarded.
REQ-028 period changes SHALL take effect only at the next counter load.
REQ-029 tick and spawn_ack in the same cycle in OFFER: acceptance only; the tick is not counted.

Reset
REQ-030 rst_n low SHALL immediately force: FSM IDLE, spawn_valid=0, lane=0, position=0, check all ones, counter=0, repeat count=0, last lane=none, LFSR=seed.
REQ-031 Release of rst_n SHALL be sampled on ck; first enable-driven transition occurs no earlier than the first edge after release.
REQ-032 Reset asserted mid-OFFER SHALL drop spawn_valid without any acceptance being recorded.

Verification
REQ-033 Defaults, enable=1, period=3, tick every 4 cycles, ack 2 cycles after valid -> valid rises 1 cycle after 3rd tick; position in {0,125,250,375}; check has exactly one zero at bit lane.
REQ-034 period=0 -> offer after every tick; ticks during OFFER with ack held low 10 cycles -> no extra offers, outputs stable.
REQ-035 MAX_REPEAT=1, force LFSR to yield lane 2 twice -> second offer lane 3, position 375, check 4'b0111.
REQ-036 NUM_LANES=3, LANE_PITCH=200, POS_W=10, LFSR low bits 2'b11 -> lane 0, position 0; no lane >= 3 over 10000 offers.
REQ-037 enable dropped during OFFER -> next cycle spawn_valid=0, check all ones; re-enable -> full period counted before next offer.
REQ-038 rst_n pulsed low mid-COUNT asynchronously -> outputs at reset values before next ck edge; LFSR sequence restarts from seed.
